pulse_stretch_tx: RTL
=====================

# pulse_stretch_tx

Transmit-side companion to the fast-to-slow pulse synchronizer. It runs in a single clock domain and accepts single-cycle event pulses at an arbitrary rate. Each accepted event is re-issued as a stretched pulse of fixed width followed by a guaranteed low gap, so a slower consumer can sample every event. Events that arrive while a pulse is in flight are queued in a saturating pending counter; events lost to saturation are reported through a sticky overflow flag.

## Interface
Parameters:
- HIGH_CYC, default 5, pulse_out high time in clk cycles (≥1)
- GAP_CYC, default 5, minimum pulse_out low time between pulses (≥1)
- CNT_W, default 4, pending counter width; maximum queued events = 2^CNT_W−1

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- pulse_in  in  1  event strobe; each high cycle counts as one event
- clr_ovf  in  1  clears overflow
- pulse_out  out  1  stretched output pulse, registered
- busy  out  1  high when the FSM is not in IDLE
- pending  out  CNT_W  events queued but not yet launched
- overflow  out  1  sticky; set when an event is dropped

## Operation
- FSM states: IDLE, HIGH, GAP. pulse_out = (state == HIGH), registered.
- Launch: the transition into HIGH consumes exactly one event.
  - From IDLE: launch if pulse_in=1 or pending≠0. If pending=0, pulse_in is consumed directly and pending stays 0.
  - From GAP, at its last cycle: if pending≠0 or pulse_in=1, go directly to HIGH and skip IDLE. Otherwise go to IDLE.
- HIGH lasts exactly HIGH_CYC cycles, then GAP. GAP lasts exactly GAP_CYC cycles.
- Phase counter width is $clog2(max(HIGH_CYC, GAP_CYC)+1). It reloads on every state entry.
- Pending counter per cycle:
  - +1 if pulse_in is accepted and not launched directly.
  - −1 if a launch is taken from the queue.
  - Both in the same cycle: no change.
- Saturation: when pending = 2^CNT_W−1 and there is no launch that cycle, pulse_in is dropped and overflow is set.
- overflow clears on clr_ovf. If set and clear occur in the same cycle, set wins.
- Reset values: state IDLE, pulse_out 0, busy 0, pending 0, overflow 0.
- Reset mid-operation aborts the current pulse immediately. All queued events are discarded.

## Timing
- Latency: pulse_in sampled at edge k while in IDLE gives pulse_out high for cycles k+1 … k+HIGH_CYC.
- Minimum spacing between pulse_out rising edges is HIGH_CYC+GAP_CYC.
- pending and overflow update on the edge after the causing pulse_in.
- pulse_in during HIGH or GAP never shortens or extends the current pulse.
- An event arriving on the last GAP cycle launches with no idle cycle.

## Structure
- Shared package pulse_pkg holds:
  - typedef enum for FSM states (IDLE, HIGH, GAP)
  - default HIGH_CYC, GAP_CYC and CNT_W constants
- One sub-module, evt_cnt: saturating up/down counter with inc, dec and sat outputs, parameterised by CNT_W. The FSM and phase counter stay in the top level.

## Test plan
- Single pulse: with HIGH=5, GAP=5, pulse_in at cycle 10 → pulse_out high cycles 11–15, busy high 11–20, IDLE at 21, pending stays 0.
- Back-to-back events: pulse_in at cycles 10 and 11 → pending=1 at cycle 12; second pulse high 21–25 (no IDLE cycle); pending 0 from cycle 21.
- Overflow (CNT_W=2): pulse_in held high cycles 10–15 from IDLE → launch at 10; pending reaches 3; events at 14 and 15 are dropped; overflow=1 from cycle 15; exactly 4 output pulses total.
- Coincident increment and launch: pending=1 and pulse_in high on the last GAP cycle → new pulse starts and pending remains 1.
- Reset mid-HIGH: rst asserted during the third HIGH cycle with pending=2 → pulse_out, busy and pending go to 0 immediately; no pulses after rst deasserts until a new pulse_in.
- Overflow clear priority: clr_ovf and a dropped event in the same cycle → overflow stays 1. clr_ovf alone → overflow is 0 next cycle.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse stretcher transmit side.
package pulse_pkg;

  localparam int DEF_HIGH_CYC = 5;
  localparam int DEF_GAP_CYC  = 5;
  localparam int DEF_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } pulse_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/evt_cnt.sv
// Saturating up/down event counter; simultaneous inc and dec leave the count unchanged.
module evt_cnt
  import pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_sat   = (r_count == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !o_sat) begin
      r_count <= r_count + CNT_ONE;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pulse_stretch_tx.sv
// Stretches single-cycle events into fixed-width pulses separated by a guaranteed low gap,
// queueing events that arrive while a pulse is in flight.
module pulse_stretch_tx
  import pulse_pkg::*;
#(
  parameter int HIGH_CYC = DEF_HIGH_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int PH_W = $clog2(max_int(HIGH_CYC, GAP_CYC) + 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] PH_GAP  = PH_W'(GAP_CYC - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  pulse_state_e     r_state;
  pulse_state_e     w_state_next;
  logic [PH_W-1:0]  r_phase;
  logic [PH_W-1:0]  w_phase_next;
  logic             r_pulse_out;
  logic             r_overflow;

  logic             w_phase_done;
  logic             w_have_evt;
  logic             w_launch;
  logic             w_from_queue;
  logic             w_direct;
  logic             w_inc;
  logic             w_dec;
  logic             w_sat;
  logic             w_drop;
  logic [CNT_W-1:0] w_pending;

  assign w_phase_done = (r_phase == '0);
  assign w_have_evt   = pulse_in || (w_pending != '0);

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_launch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_have_evt) begin
          w_launch = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_phase_done) begin
          w_state_next = ST_GAP;
          w_phase_next = PH_GAP;
        end else begin
          w_phase_next = r_phase - PH_ONE;
        end
      end
      ST_GAP: begin
        // Last gap cycle chains straight into the next pulse when work is waiting.
        if (w_phase_done) begin
          if (w_have_evt) begin
            w_launch = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_phase_next = r_phase - PH_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_launch) begin
      w_state_next = ST_HIGH;
      w_phase_next = PH_HIGH;
    end
  end

  // An empty queue lets pulse_in launch directly without touching the counter.
  assign w_from_queue = w_launch && (w_pending != '0);
  assign w_direct     = w_launch && (w_pending == '0);
  assign w_inc        = pulse_in && !w_direct;
  assign w_dec        = w_from_queue;
  assign w_drop       = w_inc && w_sat && !w_dec;

  evt_cnt #(
    .CNT_W(CNT_W)
  ) u_evt_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_inc),
    .i_dec  (w_dec),
    .o_count(w_pending),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_pulse_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_pulse_out <= (w_state_next == ST_HIGH);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign pulse_out = r_pulse_out;
  assign busy      = (r_state != ST_IDLE);
  assign pending   = w_pending;
  assign overflow  = r_overflow;

endmodule
